// File: rtl/aurora_link_supervisor.sv
// Aurora link supervisor (init_clk domain): gt_reset/reset power-up sequencing,
// debounced channel_up supervision, bounded automatic re-init and sticky hard-fail.
module aurora_link_supervisor #(
    parameter int GT_RST_CYCLES   = 16,
    parameter int RST_HOLD_CYCLES = 8,
    parameter int UP_TIMEOUT      = 4096,
    parameter int DEBOUNCE        = 4,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       init_clk,
    input  logic       RST,
    input  logic       channel_up,
    input  logic       retry_req,
    output logic       reset_aurora,
    output logic       gt_reset,
    output logic       link_ok,
    output logic       link_lost,
    output logic       link_fail,
    output logic [3:0] retry_count
);
    localparam int MAX_A   = (GT_RST_CYCLES > RST_HOLD_CYCLES) ? GT_RST_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_MAX = (UP_TIMEOUT > MAX_A) ? UP_TIMEOUT : MAX_A;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        RESET_GT,
        RELEASE_GT,
        WAIT_UP,
        LINK_UP,
        RETRY,
        FAIL
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   timer;
    logic               sync1, sync2;
    logic               up_f;
    logic [DEB_W-1:0]   deb_cnt;
    logic               reenter, count_clr, count_inc, lost;

    // NOTE: non-blocking assignments make sync1 -> sync2 a true two-flop pipeline.
    always_ff @(posedge init_clk) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= channel_up;
            sync2 <= sync1;
        end
    end

    // up_f flips only after DEBOUNCE consecutive samples that disagree with it.
    always_ff @(posedge init_clk) begin
        if (RST) begin
            up_f    <= 1'b0;
            deb_cnt <= '0;
        end else if (sync2 == up_f) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
            up_f    <= sync2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        count_clr  = 1'b0;
        count_inc  = 1'b0;
        lost       = 1'b0;
        case (state)
            RESET_GT:   if (timer == CNT_W'(GT_RST_CYCLES - 1)) state_next = RELEASE_GT;
            RELEASE_GT: if (timer == CNT_W'(RST_HOLD_CYCLES - 1)) state_next = WAIT_UP;
            WAIT_UP: begin
                if (up_f)                                     state_next = LINK_UP;
                else if (timer == CNT_W'(UP_TIMEOUT - 1))     state_next = RETRY;
            end
            LINK_UP: begin
                if (!up_f) begin
                    state_next = RETRY;
                    lost       = 1'b1;
                end else if (timer == CNT_W'(UP_TIMEOUT - 1)) begin
                    count_clr = 1'b1;
                end
            end
            RETRY: begin
                if (retry_count < 4'(MAX_RETRIES)) begin
                    count_inc  = 1'b1;
                    state_next = RESET_GT;
                end else begin
                    state_next = FAIL;
                end
            end
            FAIL:    state_next = FAIL;
            default: state_next = RESET_GT;
        endcase
        // A software retry overrides any event detected in the same cycle.
        if (retry_req) begin
            state_next = RESET_GT;
            count_clr  = 1'b1;
            count_inc  = 1'b0;
            lost       = 1'b0;
        end
        reenter = retry_req || (state_next != state);
    end

    always_ff @(posedge init_clk) begin
        if (RST) begin
            state        <= RESET_GT;
            timer        <= '0;
            retry_count  <= '0;
            reset_aurora <= 1'b1;
            gt_reset     <= 1'b1;
            link_ok      <= 1'b0;
            link_lost    <= 1'b0;
            link_fail    <= 1'b0;
        end else begin
            state <= state_next;
            // Timer saturates so the stable-up clear fires once per LINK_UP entry.
            if (reenter)                        timer <= '0;
            else if (timer != CNT_W'(CNT_MAX))  timer <= timer + 1'b1;
            if (count_clr)                                retry_count <= '0;
            else if (count_inc && retry_count != 4'hF)    retry_count <= retry_count + 4'd1;
            reset_aurora <= (state_next == RESET_GT) || (state_next == RELEASE_GT) || (state_next == FAIL);
            gt_reset     <= (state_next == RESET_GT) || (state_next == FAIL);
            link_ok      <= (state_next == LINK_UP);
            link_lost    <= lost;
            link_fail    <= (state_next == FAIL);
        end
    end
endmodule
